// File: rtl/pipe_fft_pkg.sv
// Shared constants for the pipeFFT stage controllers.
// RD_LAT is the micro-RAM read latency (registered address plus registered data).
package pipe_fft_pkg;

  localparam int RD_LAT  = 2;
  localparam int OUT_LAT = RD_LAT + 1;

endpackage

// File: rtl/pipe_fft_vld_pipe.sv
// Valid shift register with synchronous flush, reusable by any pipeFFT stage controller.
// Stage 0 captures in_vld; pre_vld is the next-to-last stage and out_vld is the last one.
module pipe_fft_vld_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic nGrst,
  input  logic flush,
  input  logic in_vld,
  output logic pre_vld,
  output logic out_vld
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  generate
    if (DEPTH < 2) begin : g_depth_chk
      $error("pipe_fft_vld_pipe: DEPTH must be at least 2");
    end
  endgenerate

  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], in_vld};
    if (flush) stage_d = '0;
  end

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign pre_vld = stage_q[DEPTH-2];
  assign out_vld = stage_q[DEPTH-1];

endmodule

// File: rtl/pipe_fft_dly_ctrl.sv
// Drives a registered-read dual-port micro-RAM as a delay line of DELAY accepted samples.
// The read pointer trails the write pointer by DELAY, so each sample re-emerges DELAY accepts later.
module pipe_fft_dly_ctrl
  import pipe_fft_pkg::*;
#(
  parameter int DW    = 66,
  parameter int AW    = 1,
  parameter int DELAY = 1
) (
  input  logic          clk,
  input  logic          nGrst,
  input  logic          clr,
  input  logic          inVld,
  input  logic [DW-1:0] inD,
  output logic [DW-1:0] wD,
  output logic [AW-1:0] wAddr,
  output logic          wEn,
  output logic [AW-1:0] rAddr,
  input  logic [DW-1:0] rD,
  output logic          outVld,
  output logic [DW-1:0] outD,
  output logic          primed
);

  localparam int            FW       = $clog2(DELAY + 1);
  localparam logic [AW-1:0] DLY_A    = AW'(DELAY);
  localparam logic [FW-1:0] FILL_MAX = FW'(DELAY);

  generate
    if (DELAY < 1 || DELAY >= (1 << AW)) begin : g_delay_chk
      $error("pipe_fft_dly_ctrl: DELAY must lie in 1..2**AW-1");
    end
  endgenerate

  logic [AW-1:0] wptr_q, wptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          accept;
  logic          issue;
  logic          data_vld;
  logic          out_vld;

  // clr beats a simultaneous inVld: the sample is dropped and nothing is written.
  always_comb begin
    accept = inVld & ~clr;
    issue  = accept & primed;
    wptr_d = wptr_q;
    fill_d = fill_q;
    if (clr) begin
      wptr_d = '0;
      fill_d = '0;
    end else if (accept) begin
      wptr_d = wptr_q + AW'(1);
      if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
    end
    hold_d = hold_q;
    if (data_vld && !clr) hold_d = rD;
  end

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      wptr_q <= '0;
      fill_q <= '0;
      hold_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      fill_q <= fill_d;
      hold_q <= hold_d;
    end
  end

  pipe_fft_vld_pipe #(
    .DEPTH (OUT_LAT)
  ) u_vld_pipe (
    .clk     (clk),
    .nGrst   (nGrst),
    .flush   (clr),
    .in_vld  (issue),
    .pre_vld (data_vld),
    .out_vld (out_vld)
  );

  assign wEn    = accept;
  assign wD     = inD;
  assign wAddr  = wptr_q;
  assign rAddr  = wptr_q - DLY_A;
  assign primed = (fill_q == FILL_MAX);
  assign outVld = out_vld;
  assign outD   = hold_q;

endmodule

// File: tb/tb_pipe_fft_dly_ctrl.sv
// Directed bench for pipe_fft_dly_ctrl: a DELAY=1/AW=1 instance checked against a hand table,
// and a DELAY=5/AW=3 instance checked cycle by cycle against a queue-based delay-line model.
module tb_pipe_fft_dly_ctrl;

  localparam int BDELAY = 5;

  logic clk;
  logic nGrst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DW=66, AW=1, DELAY=1
  logic        aClr, aInVld, aWEn, aOutVld, aPrimed;
  logic [65:0] aInD, aWD, aRD, aOutD;
  logic [0:0]  aWAddr, aRAddr, aRAddrQ;
  logic [65:0] aMem [2];

  // Instance B: DW=16, AW=3, DELAY=5
  logic        bClr, bInVld, bWEn, bOutVld, bPrimed;
  logic [15:0] bInD, bWD, bRD, bOutD;
  logic [2:0]  bWAddr, bRAddr, bRAddrQ;
  logic [15:0] bMem [8];

  pipe_fft_dly_ctrl #(.DW(66), .AW(1), .DELAY(1)) dutA (
    .clk(clk), .nGrst(nGrst), .clr(aClr), .inVld(aInVld), .inD(aInD),
    .wD(aWD), .wAddr(aWAddr), .wEn(aWEn), .rAddr(aRAddr), .rD(aRD),
    .outVld(aOutVld), .outD(aOutD), .primed(aPrimed)
  );

  pipe_fft_dly_ctrl #(.DW(16), .AW(3), .DELAY(BDELAY)) dutB (
    .clk(clk), .nGrst(nGrst), .clr(bClr), .inVld(bInVld), .inD(bInD),
    .wD(bWD), .wAddr(bWAddr), .wEn(bWEn), .rAddr(bRAddr), .rD(bRD),
    .outVld(bOutVld), .outD(bOutD), .primed(bPrimed)
  );

  // Micro-RAM models: registered read address, registered read data, read-before-write.
  always @(posedge clk) begin
    if (aWEn) aMem[aWAddr] <= aWD;
    aRAddrQ <= aRAddr;
    aRD     <= aMem[aRAddrQ];
    if (bWEn) bMem[bWAddr] <= bWD;
    bRAddrQ <= bRAddr;
    bRD     <= bMem[bRAddrQ];
  end

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkOutput(input string tag, input logic [65:0] observed, input logic [65:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, return at the falling edge for sampling.
  task automatic applyStimulus(input bit toB, input logic vld, input logic clr, input logic [65:0] d);
    @(posedge clk);
    #1;
    if (toB) begin
      bInVld = vld; bClr = clr; bInD = d[15:0];
      aInVld = 1'b0; aClr = 1'b0;
    end else begin
      aInVld = vld; aClr = clr; aInD = d;
      bInVld = 1'b0; bClr = 1'b0;
    end
    @(negedge clk);
  endtask

  // Reference model for instance B
  typedef struct {
    int          due;
    logic [15:0] data;
  } pend_t;

  int          mWPtr, mFill, mCycle, dutOutCount;
  logic [15:0] mOutD;
  logic [15:0] hist[$];
  pend_t       pend[$];

  task automatic modelReset();
    mWPtr = 0;
    mFill = 0;
    mOutD = '0;
    hist.delete();
    pend.delete();
  endtask

  task automatic stepB(input logic vld, input logic clr, input logic [15:0] d);
    logic  accept;
    logic  expVld;
    pend_t p;
    applyStimulus(1'b1, vld, clr, {50'b0, d});
    accept = vld & ~clr;
    checkOutput($sformatf("b_wEn@%0d", mCycle), bWEn, accept);
    if (accept) checkOutput($sformatf("b_wD@%0d", mCycle), bWD, d);
    checkOutput($sformatf("b_wAddr@%0d", mCycle), bWAddr, 66'(mWPtr));
    checkOutput($sformatf("b_rAddr@%0d", mCycle), bRAddr, 66'((mWPtr + 8 - BDELAY) % 8));
    checkOutput($sformatf("b_primed@%0d", mCycle), bPrimed, mFill == BDELAY);
    expVld = (pend.size() > 0) && (pend[0].due == mCycle);
    if (expVld) begin
      mOutD = pend[0].data;
      void'(pend.pop_front());
    end
    checkOutput($sformatf("b_outVld@%0d", mCycle), bOutVld, expVld);
    checkOutput($sformatf("b_outD@%0d", mCycle), bOutD, mOutD);
    if (bOutVld) dutOutCount++;
    if (accept) begin
      if (mFill == BDELAY) begin
        p.due  = mCycle + 3;
        p.data = hist[hist.size() - BDELAY];
        pend.push_back(p);
      end
      hist.push_back(d);
      mWPtr = (mWPtr + 1) % 8;
      if (mFill < BDELAY) mFill++;
    end
    if (clr) begin
      mWPtr = 0;
      mFill = 0;
      hist.delete();
      pend.delete();
    end
    mCycle++;
  endtask

  // Hand-computed expectations for instance A fed 1..5 then idle.
  int expAVld    [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  int expAD      [9] = '{0, 0, 0, 0, 1, 2, 3, 4, 4};
  int expAPrimed [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
  int expAWAddr  [9] = '{0, 1, 0, 1, 0, 1, 1, 1, 1};

  initial begin
    int accepted;
    aClr = 0; aInVld = 0; aInD = '0;
    bClr = 0; bInVld = 0; bInD = '0;
    mCycle = 0;
    dutOutCount = 0;
    modelReset();
    nGrst = 1'b1;
    #2 nGrst = 1'b0;
    #1;
    checkOutput("rst_a_wAddr", aWAddr, 0);
    checkOutput("rst_a_rAddr", aRAddr, 1);
    checkOutput("rst_a_wEn", aWEn, 0);
    checkOutput("rst_a_primed", aPrimed, 0);
    checkOutput("rst_a_outVld", aOutVld, 0);
    checkOutput("rst_a_outD", aOutD, 0);
    checkOutput("rst_b_wAddr", bWAddr, 0);
    checkOutput("rst_b_rAddr", bRAddr, 3);
    checkOutput("rst_b_primed", bPrimed, 0);
    checkOutput("rst_b_outVld", bOutVld, 0);
    @(negedge clk);
    @(negedge clk);
    nGrst = 1'b1;

    $display("[TB] instance A: DELAY=1 directed table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, i < 5, 1'b0, 66'(i + 1));
      checkOutput($sformatf("a_wEn@%0d", i), aWEn, i < 5);
      checkOutput($sformatf("a_wAddr@%0d", i), aWAddr, 66'(expAWAddr[i]));
      checkOutput($sformatf("a_rAddr@%0d", i), aRAddr, 66'(expAWAddr[i] ^ 1));
      checkOutput($sformatf("a_primed@%0d", i), aPrimed, 66'(expAPrimed[i]));
      checkOutput($sformatf("a_outVld@%0d", i), aOutVld, 66'(expAVld[i]));
      checkOutput($sformatf("a_outD@%0d", i), aOutD, 66'(expAD[i]));
    end

    $display("[TB] instance B: 20 continuous samples across wrap");
    dutOutCount = 0;
    for (int i = 0; i < 20; i++) stepB(1'b1, 1'b0, 16'(i));
    for (int i = 0; i < 5; i++) stepB(1'b0, 1'b0, 16'h0);
    checkOutput("b1_outCount", 66'(dutOutCount), 15);

    $display("[TB] instance B: random gaps, 200 samples");
    stepB(1'b0, 1'b1, 16'h0);
    dutOutCount = 0;
    accepted = 0;
    for (int c = 0; c < 3000 && accepted < 200; c++) begin
      logic v;
      v = ($urandom_range(0, 9) < 4);
      stepB(v, 1'b0, 16'($urandom));
      if (v) accepted++;
    end
    for (int i = 0; i < 5; i++) stepB(1'b0, 1'b0, 16'h0);
    checkOutput("b2_outCount", 66'(dutOutCount), 195);

    $display("[TB] instance B: clr with reads in flight, clr with inVld");
    stepB(1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 8; i++) stepB(1'b1, 1'b0, 16'(16'h100 + i));
    stepB(1'b1, 1'b1, 16'h00AA);
    for (int i = 0; i < 10; i++) stepB(1'b1, 1'b0, 16'(16'h200 + i));
    stepB(1'b1, 1'b1, 16'h00AA);
    for (int i = 0; i < 5; i++) stepB(1'b0, 1'b0, 16'h0);

    $display("[TB] instance B: async reset mid-stream");
    for (int i = 0; i < 12; i++) stepB(1'b1, 1'b0, 16'(16'h300 + i));
    @(posedge clk);
    #2;
    bInVld = 1'b0;
    nGrst  = 1'b0;
    #1;
    checkOutput("mid_rst_b_wAddr", bWAddr, 0);
    checkOutput("mid_rst_b_rAddr", bRAddr, 3);
    checkOutput("mid_rst_b_wEn", bWEn, 0);
    checkOutput("mid_rst_b_primed", bPrimed, 0);
    checkOutput("mid_rst_b_outVld", bOutVld, 0);
    checkOutput("mid_rst_b_outD", bOutD, 0);
    modelReset();
    @(negedge clk);
    nGrst = 1'b1;
    for (int i = 0; i < 10; i++) stepB(1'b1, 1'b0, 16'(16'h400 + i));
    for (int i = 0; i < 5; i++) stepB(1'b0, 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
